// File: rtl/gtx_8x10enc_pkg.sv
// Shared 8b/10b definitions: running-disparity encoding, legal K code
// points and the mapping from the abcdei/fghj notation to wire order.
package gtx_8x10enc_pkg;

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_e;

    // x (EDCBA) values that have a K form; only K28 exists for every y
    localparam logic [4:0] K28 = 5'd28;
    localparam logic [4:0] K23 = 5'd23;
    localparam logic [4:0] K27 = 5'd27;
    localparam logic [4:0] K29 = 5'd29;
    localparam logic [4:0] K30 = 5'd30;

    // Tables are written as in the literature (a, f on the left); on the
    // wire bit0 is 'a' and bit9 is 'j'.
    function automatic logic [9:0] pack_symbol(input logic [5:0] abcdei,
                                               input logic [3:0] fghj);
        logic [9:0] s;
        s = '0;
        for (int i = 0; i < 6; i++) s[i] = abcdei[5-i];
        for (int i = 0; i < 4; i++) s[6+i] = fghj[3-i];
        return s;
    endfunction

endpackage

// File: rtl/gtx_8x10enc_byte.sv
// Combinational 8b/10b encode of one byte for both entering disparities,
// plus the symbol's non-neutral flag and the illegal-K flag.
module gtx_8x10enc_byte
    import gtx_8x10enc_pkg::*;
(
    input  logic [7:0] data,
    input  logic       isk,
    output logic [9:0] code_m,
    output logic [9:0] code_p,
    output logic       flip,
    output logic       invalid_k
);

    // 5b/6b data table: {RD- code, RD+ code} in abcdei order
    function automatic logic [11:0] six_pair(input logic [4:0] x);
        case (x)
            5'd0:    return {6'b100111, 6'b011000};
            5'd1:    return {6'b011101, 6'b100010};
            5'd2:    return {6'b101101, 6'b010010};
            5'd3:    return {6'b110001, 6'b110001};
            5'd4:    return {6'b110101, 6'b001010};
            5'd5:    return {6'b101001, 6'b101001};
            5'd6:    return {6'b011001, 6'b011001};
            5'd7:    return {6'b111000, 6'b000111};
            5'd8:    return {6'b111001, 6'b000110};
            5'd9:    return {6'b100101, 6'b100101};
            5'd10:   return {6'b010101, 6'b010101};
            5'd11:   return {6'b110100, 6'b110100};
            5'd12:   return {6'b001101, 6'b001101};
            5'd13:   return {6'b101100, 6'b101100};
            5'd14:   return {6'b011100, 6'b011100};
            5'd15:   return {6'b010111, 6'b101000};
            5'd16:   return {6'b011011, 6'b100100};
            5'd17:   return {6'b100011, 6'b100011};
            5'd18:   return {6'b010011, 6'b010011};
            5'd19:   return {6'b110010, 6'b110010};
            5'd20:   return {6'b001011, 6'b001011};
            5'd21:   return {6'b101010, 6'b101010};
            5'd22:   return {6'b011010, 6'b011010};
            5'd23:   return {6'b111010, 6'b000101};
            5'd24:   return {6'b110011, 6'b001100};
            5'd25:   return {6'b100110, 6'b100110};
            5'd26:   return {6'b010110, 6'b010110};
            5'd27:   return {6'b110110, 6'b001001};
            5'd28:   return {6'b001110, 6'b001110};
            5'd29:   return {6'b101110, 6'b010001};
            5'd30:   return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    // 3b/4b data table: {RD- code, RD+ code} in fghj order, RD taken after the 6b subblock
    function automatic logic [7:0] d_four(input logic [2:0] y, input logic a7);
        case (y)
            3'd0:    return {4'b1011, 4'b0100};
            3'd1:    return {4'b1001, 4'b1001};
            3'd2:    return {4'b0101, 4'b0101};
            3'd3:    return {4'b1100, 4'b0011};
            3'd4:    return {4'b1101, 4'b0010};
            3'd5:    return {4'b1010, 4'b1010};
            3'd6:    return {4'b0110, 4'b0110};
            default: return a7 ? {4'b0111, 4'b1000} : {4'b1110, 4'b0001};
        endcase
    endfunction

    // 3b/4b table specific to K28.y
    function automatic logic [7:0] k28_four(input logic [2:0] y);
        case (y)
            3'd0:    return {4'b1011, 4'b0100};
            3'd1:    return {4'b0110, 4'b1001};
            3'd2:    return {4'b1010, 4'b0101};
            3'd3:    return {4'b1100, 4'b0011};
            3'd4:    return {4'b1101, 4'b0010};
            3'd5:    return {4'b0101, 4'b1010};
            3'd6:    return {4'b1001, 4'b0110};
            default: return {4'b0111, 4'b1000};
        endcase
    endfunction

    function automatic logic [9:0] encode(input logic [7:0] b, input logic k28,
                                          input logic kx7, input rd_e rd);
        logic [4:0]  x;
        logic [2:0]  y;
        logic [11:0] pair6;
        logic [7:0]  pair4;
        logic [5:0]  c6;
        logic [3:0]  c4;
        logic        a7;
        rd_e         rd6;
        x     = b[4:0];
        y     = b[7:5];
        pair6 = k28 ? {6'b001111, 6'b110000} : six_pair(x);
        c6    = (rd == RD_POS) ? pair6[5:0] : pair6[11:6];
        rd6   = ($countones(c6) == 3) ? rd : ((rd == RD_POS) ? RD_NEG : RD_POS);
        a7    = ((rd6 == RD_NEG) && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                ((rd6 == RD_POS) && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        if (k28)      pair4 = k28_four(y);
        else if (kx7) pair4 = {4'b0111, 4'b1000};
        else          pair4 = d_four(y, a7);
        c4 = (rd6 == RD_POS) ? pair4[3:0] : pair4[7:4];
        return pack_symbol(c6, c4);
    endfunction

    logic k28;
    logic kx7;

    // Classify the K request, then encode both RD variants in parallel
    always_comb begin
        // NOTE: every signal here is assigned on every pass through the block, so no latch is inferred.
        k28       = isk && (data[4:0] == K28);
        kx7       = isk && (data[7:5] == 3'd7) &&
                    (data[4:0] == K23 || data[4:0] == K27 ||
                     data[4:0] == K29 || data[4:0] == K30);
        invalid_k = isk && !(k28 || kx7);
        code_m    = encode(data, k28, kx7, RD_NEG);
        code_p    = encode(data, k28, kx7, RD_POS);
        flip      = ($countones(code_m) != 5);
    end

endmodule

// File: rtl/gtx_8x10enc.sv
// Two-byte-per-clock 8b/10b encoder for the SATA host TX path. Input
// register, stage1 holds both RD variants per byte, stage2 resolves RD.
module gtx_8x10enc
    import gtx_8x10enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] indata,
    input  logic [1:0]  inisk,
    output logic [19:0] outdata,
    output logic [1:0]  invalid_k,
    output logic        disparity
);

    logic [15:0] in_data_q;
    logic [1:0]  in_isk_q;
    logic        in_valid_q;

    logic [9:0]  enc0_m, enc0_p, enc1_m, enc1_p;
    logic        enc0_flip, enc1_flip, enc0_invk, enc1_invk;

    logic [9:0]  s1_code0_m, s1_code0_p, s1_code1_m, s1_code1_p;
    logic [1:0]  s1_flip;
    logic [1:0]  s1_invk;

    logic        rd;
    logic        rd_mid, rd_next;
    logic [9:0]  sym0, sym1;

    // Input register; valid marks that a real word (not the reset value) is held
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            in_data_q  <= '0;
            in_isk_q   <= '0;
            in_valid_q <= 1'b0;
        end else begin
            in_data_q  <= indata;
            in_isk_q   <= inisk;
            in_valid_q <= 1'b1;
        end
    end

    gtx_8x10enc_byte u_byte0 (
        .data      (in_data_q[7:0]),
        .isk       (in_isk_q[0]),
        .code_m    (enc0_m),
        .code_p    (enc0_p),
        .flip      (enc0_flip),
        .invalid_k (enc0_invk)
    );

    gtx_8x10enc_byte u_byte1 (
        .data      (in_data_q[15:8]),
        .isk       (in_isk_q[1]),
        .code_m    (enc1_m),
        .code_p    (enc1_p),
        .flip      (enc1_flip),
        .invalid_k (enc1_invk)
    );

    // Stage1: both RD candidates per byte; stays all-zero until a real word arrives after reset
    always_ff @(posedge clk) begin
        if (!rst_n || !in_valid_q) begin
            s1_code0_m <= '0;
            s1_code0_p <= '0;
            s1_code1_m <= '0;
            s1_code1_p <= '0;
            s1_flip    <= '0;
            s1_invk    <= '0;
        end else begin
            s1_code0_m <= enc0_m;
            s1_code0_p <= enc0_p;
            s1_code1_m <= enc1_m;
            s1_code1_p <= enc1_p;
            s1_flip    <= {enc1_flip, enc0_flip};
            s1_invk    <= {enc1_invk, enc0_invk};
        end
    end

    // RD loop: byte0 uses registered RD, byte1 the RD left by symbol0
    always_comb begin
        sym0    = rd ? s1_code0_p : s1_code0_m;
        rd_mid  = rd ^ s1_flip[0];
        sym1    = rd_mid ? s1_code1_p : s1_code1_m;
        rd_next = rd_mid ^ s1_flip[1];
    end

    // Stage2: output symbols, K flags and running disparity
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outdata   <= '0;
            invalid_k <= '0;
            rd        <= RD_NEG;
        end else begin
            outdata   <= {sym1, sym0};
            invalid_k <= s1_invk;
            rd        <= rd_next;
        end
    end

    assign disparity = rd;

endmodule
